// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register bank: FunSel encodings and the
// next-state function used by both the register cells and the read bypass.
// Ports: none (package).
// ---------------------------------------------------------------------------
package reg_file_pkg;

    localparam logic [2:0] FS_CLR = 3'b000;
    localparam logic [2:0] FS_LD  = 3'b001;
    localparam logic [2:0] FS_INC = 3'b010;
    localparam logic [2:0] FS_DEC = 3'b011;
    localparam logic [2:0] FS_SHL = 3'b100;
    localparam logic [2:0] FS_SHR = 3'b101;
    localparam logic [2:0] FS_ROL = 3'b110;
    localparam logic [2:0] FS_LDL = 3'b111;

    // Widest register the shared function supports; callers zero-extend into it.
    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic             wrap_set;
        logic             wrap_clr;
        logic [MAX_W-1:0] value;
    } next_t;

    // Result for a register of 'width' bits; bits above 'width' are always zero.
    function automatic next_t next_val(input logic [MAX_W-1:0] cur,
                                       input logic [MAX_W-1:0] din,
                                       input logic [2:0]       funsel,
                                       input int unsigned      width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] lo_mask;
        logic [MAX_W-1:0] cur_m;
        logic [MAX_W-1:0] msb;
        next_t            r;
        mask    = {MAX_W{1'b1}} >> (MAX_W - width);
        lo_mask = mask >> (width / 2);
        cur_m   = cur & mask;
        msb     = cur_m >> (width - 1);
        r       = '0;
        case (funsel)
            FS_CLR: begin
                r.value    = '0;
                r.wrap_clr = 1'b1;
            end
            FS_LD: begin
                r.value    = din & mask;
                r.wrap_clr = 1'b1;
            end
            FS_INC: begin
                r.value    = (cur_m + MAX_W'(1)) & mask;
                r.wrap_set = (cur_m == mask);
            end
            FS_DEC: begin
                r.value    = (cur_m - MAX_W'(1)) & mask;
                r.wrap_set = (cur_m == '0);
            end
            FS_SHL:  r.value = (cur_m << 1) & mask;
            FS_SHR:  r.value = cur_m >> 1;
            FS_ROL:  r.value = ((cur_m << 1) | msb) & mask;
            default: begin
                r.value    = din & lo_mask;
                r.wrap_clr = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reg_file_bank_if.sv
// ---------------------------------------------------------------------------
// reg_file_bank_if
// Bus bundle between the ALU side and the register bank.
//   master: drives I, FunSel, RegEn, OutASel, OutBSel; reads OutA/OutB,
//           WrapA/WrapB, ZeroA/ZeroB.
//   slave : the register bank (opposite directions).
// ---------------------------------------------------------------------------
interface reg_file_bank_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS)
);
    logic [WIDTH-1:0]    I;
    logic [2:0]          FunSel;
    logic [NUM_REGS-1:0] RegEn;
    logic [SEL_W-1:0]    OutASel;
    logic [SEL_W-1:0]    OutBSel;
    logic [WIDTH-1:0]    OutA;
    logic [WIDTH-1:0]    OutB;
    logic                WrapA;
    logic                WrapB;
    logic                ZeroA;
    logic                ZeroB;

    modport master (
        output I, FunSel, RegEn, OutASel, OutBSel,
        input  OutA, OutB, WrapA, WrapB, ZeroA, ZeroB
    );

    modport slave (
        input  I, FunSel, RegEn, OutASel, OutBSel,
        output OutA, OutB, WrapA, WrapB, ZeroA, ZeroB
    );
endinterface

// File: rtl/reg_file_cell.sv
// ---------------------------------------------------------------------------
// reg_file_cell
// One WIDTH-bit register with its sticky wrap flag.
//   Clock  : rising-edge clock
//   Reset  : synchronous active-low reset (clears value and flag)
//   enable : apply FunSel this edge
//   FunSel : function select
//   I      : write data
//   value  : current register contents
//   wrap   : current sticky wrap flag
// ---------------------------------------------------------------------------
module reg_file_cell #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enable,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);
    import reg_file_pkg::*;

    logic [WIDTH-1:0] value_q;
    logic             wrap_q;
    next_t            nv;
    logic [WIDTH-1:0] nxt_val;

    always_comb begin
        nv      = next_val(MAX_W'(value_q), MAX_W'(I), FunSel, WIDTH);
        nxt_val = WIDTH'(nv.value);
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            value_q <= '0;
            wrap_q  <= 1'b0;
        end else if (enable) begin
            value_q <= nxt_val;
            if (nv.wrap_set) begin
                wrap_q <= 1'b1;
            end else if (nv.wrap_clr) begin
                wrap_q <= 1'b0;
            end
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
endmodule

// File: rtl/reg_file_bank.sv
// ---------------------------------------------------------------------------
// reg_file_bank
// NUM_REGS x WIDTH register bank with a shared function-select write path,
// two read ports, sticky wrap flags and optional registered reads with
// write-to-read bypass.
//   Clock : rising-edge clock
//   Reset : synchronous active-low reset
//   bus   : reg_file_bank_if.slave (write data/function/enables, read
//           selects in; read data, wrap and zero flags out)
// ---------------------------------------------------------------------------
module reg_file_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter int unsigned READ_REG = 0
) (
    input  logic           Clock,
    input  logic           Reset,
    reg_file_bank_if.slave bus
);
    import reg_file_pkg::*;

    // Pad to the full select range; unused slots read as 0 with no wrap.
    localparam int unsigned NUM_SLOTS = 2 ** SEL_W;

    logic [WIDTH-1:0] reg_val  [NUM_SLOTS];
    logic             reg_wrap [NUM_SLOTS];
    logic             slot_en  [NUM_SLOTS];

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
        if (k < NUM_REGS) begin : g_cell
            reg_file_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .Clock  (Clock),
                .Reset  (Reset),
                .enable (bus.RegEn[k]),
                .FunSel (bus.FunSel),
                .I      (bus.I),
                .value  (reg_val[k]),
                .wrap   (reg_wrap[k])
            );
            assign slot_en[k] = bus.RegEn[k];
        end else begin : g_empty
            assign reg_val[k]  = '0;
            assign reg_wrap[k] = 1'b0;
            assign slot_en[k]  = 1'b0;
        end
    end

    logic [WIDTH-1:0] cur_a_val, cur_b_val;
    logic             cur_a_wrap, cur_b_wrap;
    logic [WIDTH-1:0] out_a, out_b;
    logic             wrap_a, wrap_b;

    always_comb begin
        cur_a_val  = reg_val[bus.OutASel];
        cur_b_val  = reg_val[bus.OutBSel];
        cur_a_wrap = reg_wrap[bus.OutASel];
        cur_b_wrap = reg_wrap[bus.OutBSel];
    end

    if (READ_REG != 0) begin : g_rr
        next_t            nv_a, nv_b;
        logic [WIDTH-1:0] post_a_val, post_b_val;
        logic             post_a_wrap, post_b_wrap;

        // Bypass: present the value the selected register holds after this edge.
        always_comb begin
            nv_a        = next_val(MAX_W'(cur_a_val), MAX_W'(bus.I), bus.FunSel, WIDTH);
            nv_b        = next_val(MAX_W'(cur_b_val), MAX_W'(bus.I), bus.FunSel, WIDTH);
            post_a_val  = cur_a_val;
            post_a_wrap = cur_a_wrap;
            post_b_val  = cur_b_val;
            post_b_wrap = cur_b_wrap;
            if (slot_en[bus.OutASel]) begin
                post_a_val  = WIDTH'(nv_a.value);
                post_a_wrap = nv_a.wrap_set | (cur_a_wrap & ~nv_a.wrap_clr);
            end
            if (slot_en[bus.OutBSel]) begin
                post_b_val  = WIDTH'(nv_b.value);
                post_b_wrap = nv_b.wrap_set | (cur_b_wrap & ~nv_b.wrap_clr);
            end
        end

        always_ff @(posedge Clock) begin
            if (!Reset) begin
                out_a  <= '0;
                out_b  <= '0;
                wrap_a <= 1'b0;
                wrap_b <= 1'b0;
            end else begin
                out_a  <= post_a_val;
                out_b  <= post_b_val;
                wrap_a <= post_a_wrap;
                wrap_b <= post_b_wrap;
            end
        end
    end else begin : g_comb
        assign out_a  = cur_a_val;
        assign out_b  = cur_b_val;
        assign wrap_a = cur_a_wrap;
        assign wrap_b = cur_b_wrap;
    end

    assign bus.OutA  = out_a;
    assign bus.OutB  = out_b;
    assign bus.WrapA = wrap_a;
    assign bus.WrapB = wrap_b;
    // Zero flags follow the driven outputs, so they share the read latency.
    assign bus.ZeroA = (out_a == '0);
    assign bus.ZeroB = (out_b == '0);
endmodule

// File: tb/tb_reg_file_bank.sv
module tb_reg_file_bank;
    import reg_file_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // d0: 8 regs combinational, d1: 8 regs registered, d2: 6 regs registered
    reg_file_bank_if #(.WIDTH(16), .NUM_REGS(8)) if0 ();
    reg_file_bank_if #(.WIDTH(16), .NUM_REGS(8)) if1 ();
    reg_file_bank_if #(.WIDTH(16), .NUM_REGS(6)) if2 ();

    reg_file_bank #(.WIDTH(16), .NUM_REGS(8), .READ_REG(0)) d0 (
        .Clock (clk), .Reset (rst_n), .bus (if0));
    reg_file_bank #(.WIDTH(16), .NUM_REGS(8), .READ_REG(1)) d1 (
        .Clock (clk), .Reset (rst_n), .bus (if1));
    reg_file_bank #(.WIDTH(16), .NUM_REGS(6), .READ_REG(1)) d2 (
        .Clock (clk), .Reset (rst_n), .bus (if2));

    int n_cmp  = 0;
    int n_fail = 0;
    bit pre_ok = 1'b0;

    // Reference model: register contents as integers, wrap flags as bits.
    int unsigned mv [8];
    bit          mw [8];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ev(input int unsigned sel, input int unsigned nregs);
        return (sel < nregs) ? mv[sel] : 0;
    endfunction

    function automatic bit ew(input int unsigned sel, input int unsigned nregs);
        return (sel < nregs) ? mw[sel] : 1'b0;
    endfunction

    task automatic check_port(input string tag, input logic [15:0] o, input logic w,
                              input logic z, input int unsigned sel, input int unsigned nregs);
        int unsigned e;
        e = ev(sel, nregs);
        check({tag, "_out"}, o, 16'(e));
        check({tag, "_wrap"}, {15'd0, w}, {15'd0, ew(sel, nregs)});
        check({tag, "_zero"}, {15'd0, z}, {15'd0, (e == 0)});
    endtask

    task automatic model_step(input bit r, input int unsigned fs, input int unsigned d,
                              input logic [7:0] en);
        for (int k = 0; k < 8; k++) begin
            if (!r) begin
                mv[k] = 0;
                mw[k] = 1'b0;
            end else if (en[k]) begin
                case (fs)
                    0: begin mv[k] = 0; mw[k] = 1'b0; end
                    1: begin mv[k] = d; mw[k] = 1'b0; end
                    2: if (mv[k] == 65535) begin mv[k] = 0; mw[k] = 1'b1; end
                       else mv[k] = mv[k] + 1;
                    3: if (mv[k] == 0) begin mv[k] = 65535; mw[k] = 1'b1; end
                       else mv[k] = mv[k] - 1;
                    4: mv[k] = (mv[k] * 2) % 65536;
                    5: mv[k] = mv[k] / 2;
                    6: mv[k] = (mv[k] * 2) % 65536 + mv[k] / 32768;
                    default: begin mv[k] = d % 256; mw[k] = 1'b0; end
                endcase
            end
        end
    endtask

    task automatic step(input bit r, input logic [2:0] fs, input logic [15:0] d,
                        input logic [7:0] en, input logic [2:0] sa, input logic [2:0] sb);
        rst_n = r;
        if0.I = d; if0.FunSel = fs; if0.RegEn = en; if0.OutASel = sa; if0.OutBSel = sb;
        if1.I = d; if1.FunSel = fs; if1.RegEn = en; if1.OutASel = sa; if1.OutBSel = sb;
        if2.I = d; if2.FunSel = fs; if2.RegEn = en[5:0]; if2.OutASel = sa; if2.OutBSel = sb;
        #2;
        // Combinational port still shows the pre-write state before the edge.
        if (pre_ok) begin
            check_port("d0_pre_a", if0.OutA, if0.WrapA, if0.ZeroA, sa, 8);
            check_port("d0_pre_b", if0.OutB, if0.WrapB, if0.ZeroB, sb, 8);
        end
        @(posedge clk);
        model_step(r, fs, d, en);
        #1;
        check_port("d0_a", if0.OutA, if0.WrapA, if0.ZeroA, sa, 8);
        check_port("d0_b", if0.OutB, if0.WrapB, if0.ZeroB, sb, 8);
        check_port("d1_a", if1.OutA, if1.WrapA, if1.ZeroA, sa, 8);
        check_port("d1_b", if1.OutB, if1.WrapB, if1.ZeroB, sb, 8);
        check_port("d2_a", if2.OutA, if2.WrapA, if2.ZeroA, sa, 6);
        check_port("d2_b", if2.OutB, if2.WrapB, if2.ZeroB, sb, 6);
        pre_ok = 1'b1;
    endtask

    logic [2:0]  shift_ops [4];
    logic [15:0] shift_exp [4];

    initial begin
        shift_ops = '{FS_SHL, FS_SHR, FS_ROL, FS_LDL};
        shift_exp = '{16'h0002, 16'h4000, 16'h0003, 16'h00EF};

        step(1'b0, FS_LD, 16'h1111, 8'hFF, 3'd0, 3'd1);

        // Random traffic with occasional resets and empty enable masks.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] en;
            en = 8'($urandom);
            if ($urandom_range(7) == 0) en = 8'h00;
            step(($urandom_range(15) != 0), 3'($urandom_range(7)), 16'($urandom), en,
                 3'($urandom_range(7)), 3'($urandom_range(7)));
        end

        // Reset after random loads.
        step(1'b1, FS_LD, 16'h5A5A, 8'hFF, 3'd0, 3'd4);
        step(1'b0, FS_INC, 16'h0000, 8'h00, 3'd0, 3'd4);
        check("rst_d1_outa", if1.OutA, 16'h0000);
        check("rst_d1_zeroa", {15'd0, if1.ZeroA}, 16'h0001);
        check("rst_d1_wrapa", {15'd0, if1.WrapA}, 16'h0000);

        // Increment wrap on R3, then load clears the flag.
        step(1'b1, FS_LD, 16'hFFFF, 8'h08, 3'd3, 3'd0);
        step(1'b1, FS_INC, 16'h0000, 8'h08, 3'd3, 3'd0);
        check("inc_wrap_out", if0.OutA, 16'h0000);
        check("inc_wrap_flag", {15'd0, if0.WrapA}, 16'h0001);
        step(1'b1, FS_LD, 16'h1234, 8'h08, 3'd3, 3'd0);
        check("ld_clr_out", if0.OutA, 16'h1234);
        check("ld_clr_flag", {15'd0, if0.WrapA}, 16'h0000);

        // Multi-register decrement, each from its own value.
        step(1'b1, FS_LD, 16'h0005, 8'h01, 3'd0, 3'd2);
        step(1'b1, FS_LD, 16'h0009, 8'h04, 3'd0, 3'd2);
        step(1'b1, FS_LD, 16'h0077, 8'h02, 3'd0, 3'd2);
        step(1'b1, FS_DEC, 16'h0000, 8'h05, 3'd0, 3'd2);
        check("dec_r0", if0.OutA, 16'h0004);
        check("dec_r2", if0.OutB, 16'h0008);
        step(1'b1, FS_CLR, 16'h0000, 8'h00, 3'd1, 3'd1);
        check("dec_r1_hold", if0.OutA, 16'h0077);
        step(1'b1, FS_CLR, 16'h0000, 8'h01, 3'd0, 3'd1);
        step(1'b1, FS_DEC, 16'h0000, 8'h01, 3'd0, 3'd1);
        check("dec_under_out", if0.OutA, 16'hFFFF);
        check("dec_under_flag", {15'd0, if0.WrapA}, 16'h0001);

        // Registered bypass on both ports.
        step(1'b1, FS_LD, 16'hA5A5, 8'h04, 3'd2, 3'd2);
        check("bypass_a", if1.OutA, 16'hA5A5);
        check("bypass_b", if1.OutB, 16'hA5A5);

        // Shift, rotate and load-low-half, each from 0x8001.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, FS_LD, 16'h8001, 8'h02, 3'd1, 3'd0);
            step(1'b1, shift_ops[k], 16'hBEEF, 8'h02, 3'd1, 3'd0);
            check("shift_op", if0.OutA, shift_exp[k]);
        end

        // Reset wins over a concurrent load.
        step(1'b1, FS_LD, 16'h2222, 8'h01, 3'd0, 3'd0);
        step(1'b0, FS_LD, 16'h1111, 8'h01, 3'd0, 3'd0);
        check("rst_over_ld", if0.OutA, 16'h0000);

        // Out-of-range selects on the 6-register bank.
        step(1'b1, FS_LD, 16'h7777, 8'hFF, 3'd7, 3'd6);
        step(1'b1, FS_INC, 16'h0000, 8'h00, 3'd7, 3'd6);
        check("oor_d2_out", if2.OutA, 16'h0000);
        check("oor_d2_wrap", {15'd0, if2.WrapA}, 16'h0000);
        check("oor_d0_out", if0.OutA, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
